// File: rtl/mem_seq_pkg.sv
// mem_seq_pkg: shared types and widths for the SRAM bus sequencer.
package mem_seq_pkg;

    localparam int AVR_ADDR_W  = 24;
    localparam int SRAM_DATA_W = 16;
    localparam int CNT_W       = 4;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        RECOVER
    } state_t;

    function automatic logic [7:0] lane_sel(
        input logic [SRAM_DATA_W-1:0] d,
        input logic                   a0
    );
        return a0 ? d[15:8] : d[7:0];
    endfunction

endpackage

// File: rtl/mem_seq_if.sv
// mem_seq_if: SNES strobes, decoder hints, SRAM bus and AVR request port.
interface mem_seq_if;
    import mem_seq_pkg::*;

    logic                   SNES_RD_N;
    logic                   SNES_WR_N;
    logic                   IS_ROM;
    logic                   IS_SAVERAM;
    logic                   SRAM_ADDR0;
    logic                   MODE;
    logic [7:0]             SNES_DATA_IN;
    logic [7:0]             SNES_DATA_OUT;
    logic                   SNES_DATA_OE;
    logic [SRAM_DATA_W-1:0] SRAM_DATA_IN;
    logic [SRAM_DATA_W-1:0] SRAM_DATA_OUT;
    logic                   SRAM_DATA_OE;
    logic                   SRAM_OE_N;
    logic                   SRAM_WE_N;
    logic                   SRAM_BHE_N;
    logic                   SRAM_BLE_N;
    logic [AVR_ADDR_W-1:0]  AVR_ADDR_IN;
    logic                   AVR_ADDR_LOAD;
    logic [AVR_ADDR_W-1:0]  AVR_ADDR;
    logic                   AVR_REQ;
    logic                   AVR_WE;
    logic [7:0]             AVR_WDATA;
    logic [7:0]             AVR_RDATA;
    logic                   AVR_ACK;
    logic                   AVR_BUSY;

    modport master (
        output SNES_RD_N, SNES_WR_N, IS_ROM, IS_SAVERAM, SRAM_ADDR0,
        output SNES_DATA_IN, SRAM_DATA_IN,
        output AVR_ADDR_IN, AVR_ADDR_LOAD, AVR_REQ, AVR_WE, AVR_WDATA,
        input  MODE, SNES_DATA_OUT, SNES_DATA_OE,
        input  SRAM_DATA_OUT, SRAM_DATA_OE, SRAM_OE_N, SRAM_WE_N,
        input  SRAM_BHE_N, SRAM_BLE_N,
        input  AVR_ADDR, AVR_RDATA, AVR_ACK, AVR_BUSY
    );

    modport slave (
        input  SNES_RD_N, SNES_WR_N, IS_ROM, IS_SAVERAM, SRAM_ADDR0,
        input  SNES_DATA_IN, SRAM_DATA_IN,
        input  AVR_ADDR_IN, AVR_ADDR_LOAD, AVR_REQ, AVR_WE, AVR_WDATA,
        output MODE, SNES_DATA_OUT, SNES_DATA_OE,
        output SRAM_DATA_OUT, SRAM_DATA_OE, SRAM_OE_N, SRAM_WE_N,
        output SRAM_BHE_N, SRAM_BLE_N,
        output AVR_ADDR, AVR_RDATA, AVR_ACK, AVR_BUSY
    );

endinterface

// File: rtl/mem_sequencer_sync_edge.sv
// sync_edge: multi-flop synchronizer for an idle-high async strobe,
// with single-cycle fall/rise pulses on the synchronized level.
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_fall,
    output logic o_rise
);

    logic [STAGES-1:0] r_sh;
    logic              r_last;
    logic              w_sync;

    assign w_sync = r_sh[STAGES-1];
    assign o_fall = r_last & ~w_sync;
    assign o_rise = ~r_last & w_sync;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sh   <= '1;
            r_last <= 1'b1;
        end else begin
            r_sh   <= (r_sh << 1) | STAGES'(i_async);
            r_last <= w_sync;
        end
    end

endmodule

// File: rtl/mem_sequencer.sv
// mem_sequencer: SRAM strobe/phase sequencer for SNES cycles and AVR requests.
// Optional AVR read prefetch buffer: define MEM_SEQ_AVR_PREFETCH_EN.
module mem_sequencer
    import mem_seq_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int ACCESS_CYCLES = 4,
    parameter int AVR_INC       = 1
) (
    input logic      CLK,
    input logic      RST,
    mem_seq_if.slave bus
);

    state_t r_state, w_next;

    logic r_rd_pend, r_wr_pend, r_avr_pend, r_avr_we;
    logic r_op_side, r_op_we, r_op_en, r_op_pf, r_a0;
    logic r_mode, r_snes_oe;
    logic [7:0] r_avr_wdata, r_wbyte, r_snes_dout, r_avr_rdata;
    logic [CNT_W-1:0] r_cnt;
    logic [AVR_ADDR_W-1:0] r_avr_addr;

    logic w_rd_fall, w_rd_rise, w_wr_fall, w_wr_rise;
    logic w_arb, w_pick_snes, w_pick_avr, w_pick_pf, w_go;
    logic w_en_setup, w_cap, w_avr_done, w_busy, w_req_ok;
    logic w_pf_pend, w_hit_now, w_hit_q;
    logic [7:0] w_lane, w_pf_data;
    logic w_oe_n, w_we_n, w_bhe_n, w_ble_n, w_sram_oe;

    sync_edge #(.STAGES(SYNC_STAGES)) u_rd (
        .i_clk(CLK), .i_rst(RST), .i_async(bus.SNES_RD_N),
        .o_fall(w_rd_fall), .o_rise(w_rd_rise)
    );

    sync_edge #(.STAGES(SYNC_STAGES)) u_wr (
        .i_clk(CLK), .i_rst(RST), .i_async(bus.SNES_WR_N),
        .o_fall(w_wr_fall), .o_rise(w_wr_rise)
    );

    // Arbitration runs from IDLE and from RECOVER so a queued access
    // follows the previous one without an idle gap.
    assign w_arb       = (r_state == IDLE) || (r_state == RECOVER);
    assign w_pick_snes = w_arb & (r_rd_pend | r_wr_pend);
    assign w_pick_avr  = w_arb & ~w_pick_snes & r_avr_pend;
    assign w_pick_pf   = w_arb & ~w_pick_snes & ~r_avr_pend & w_pf_pend;
    assign w_go        = w_pick_snes | w_pick_avr | w_pick_pf;

    assign w_en_setup = r_op_side |
                        (r_op_we ? bus.IS_SAVERAM
                                 : (bus.IS_ROM | bus.IS_SAVERAM));
    assign w_lane     = lane_sel(bus.SRAM_DATA_IN, r_a0);
    assign w_cap      = (r_state == STROBE) && (r_cnt == '0) &&
                        r_op_en && !r_op_we;
    assign w_avr_done = (r_state == RECOVER) && r_op_side && !r_op_pf;
    assign w_busy     = r_avr_pend | w_hit_q |
                        ((r_state != IDLE) && r_op_side && !r_op_pf);
    assign w_req_ok   = bus.AVR_REQ && !w_busy;

    always_comb begin
        w_next    = r_state;
        w_oe_n    = 1'b1;
        w_we_n    = 1'b1;
        w_bhe_n   = 1'b1;
        w_ble_n   = 1'b1;
        w_sram_oe = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_go) w_next = SETUP;
            end
            SETUP: begin
                w_next = STROBE;
                if (w_en_setup) begin
                    w_bhe_n = ~bus.SRAM_ADDR0;
                    w_ble_n = bus.SRAM_ADDR0;
                end
            end
            STROBE: begin
                if (r_cnt == '0) w_next = RECOVER;
                if (r_op_en) begin
                    w_bhe_n = ~r_a0;
                    w_ble_n = r_a0;
                    if (r_op_we) begin
                        w_we_n    = 1'b0;
                        w_sram_oe = 1'b1;
                    end else begin
                        w_oe_n = 1'b0;
                    end
                end
            end
            RECOVER: begin
                w_next = w_go ? SETUP : IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= IDLE;
            r_rd_pend   <= 1'b0;
            r_wr_pend   <= 1'b0;
            r_avr_pend  <= 1'b0;
            r_avr_we    <= 1'b0;
            r_avr_wdata <= '0;
            r_op_side   <= 1'b0;
            r_op_we     <= 1'b0;
            r_op_en     <= 1'b0;
            r_op_pf     <= 1'b0;
            r_a0        <= 1'b0;
            r_cnt       <= '0;
            r_wbyte     <= '0;
            r_mode      <= 1'b0;
            r_snes_oe   <= 1'b0;
            r_snes_dout <= '0;
            r_avr_rdata <= '0;
            r_avr_addr  <= '0;
        end else begin
            r_state <= w_next;

            if (w_pick_snes) begin
                r_mode    <= 1'b0;
                r_op_side <= 1'b0;
                r_op_pf   <= 1'b0;
                r_op_we   <= ~r_rd_pend;
                if (r_rd_pend) r_rd_pend <= 1'b0;
                else           r_wr_pend <= 1'b0;
            end
            if (w_pick_avr) begin
                r_mode     <= 1'b1;
                r_op_side  <= 1'b1;
                r_op_pf    <= 1'b0;
                r_op_we    <= r_avr_we;
                r_avr_pend <= 1'b0;
            end
            if (w_pick_pf) begin
                r_mode    <= 1'b1;
                r_op_side <= 1'b1;
                r_op_pf   <= 1'b1;
                r_op_we   <= 1'b0;
            end
            if (w_rd_fall) r_rd_pend <= 1'b1;
            if (w_wr_fall) r_wr_pend <= 1'b1;

            if (w_req_ok && !w_hit_now) begin
                r_avr_pend  <= 1'b1;
                r_avr_we    <= bus.AVR_WE;
                r_avr_wdata <= bus.AVR_WDATA;
            end

            if (r_state == SETUP) begin
                r_a0    <= bus.SRAM_ADDR0;
                r_op_en <= w_en_setup;
                r_cnt   <= CNT_W'(ACCESS_CYCLES - 1);
                r_wbyte <= r_op_side ? r_avr_wdata : bus.SNES_DATA_IN;
            end
            if (r_state == STROBE && r_cnt != '0) r_cnt <= r_cnt - 1'b1;

            if (w_cap && !r_op_side) begin
                r_snes_dout <= w_lane;
                r_snes_oe   <= 1'b1;
            end
            if (w_cap && r_op_side && !r_op_pf) r_avr_rdata <= w_lane;
            if (w_hit_now) r_avr_rdata <= w_pf_data;
            if (w_rd_rise) r_snes_oe <= 1'b0;

            if (bus.AVR_ADDR_LOAD)
                r_avr_addr <= bus.AVR_ADDR_IN;
            else if (w_avr_done || w_hit_q)
                r_avr_addr <= r_avr_addr + AVR_ADDR_W'(AVR_INC);
        end
    end

`ifdef MEM_SEQ_AVR_PREFETCH_EN
    logic r_pf_pend, r_pf_valid, r_pf_ok, r_hit;
    logic [7:0] r_pf_data;

    assign w_pf_pend = r_pf_pend;
    assign w_pf_data = r_pf_data;
    assign w_hit_q   = r_hit;
    assign w_hit_now = w_req_ok && !bus.AVR_WE && r_pf_valid;

    // r_pf_ok drops if the pointer moves while a prefetch is in flight.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_pf_pend  <= 1'b0;
            r_pf_valid <= 1'b0;
            r_pf_ok    <= 1'b0;
            r_hit      <= 1'b0;
            r_pf_data  <= '0;
        end else begin
            r_hit <= w_hit_now;
            if (w_hit_now) r_pf_valid <= 1'b0;
            if (r_hit) r_pf_pend <= 1'b1;
            if (w_avr_done && !r_op_we) begin
                r_pf_pend  <= 1'b1;
                r_pf_valid <= 1'b0;
            end
            if (w_pick_pf) begin
                r_pf_pend <= 1'b0;
                r_pf_ok   <= 1'b1;
            end
            if (w_cap && r_op_pf) r_pf_data <= w_lane;
            if (r_state == RECOVER && r_op_pf) r_pf_valid <= r_pf_ok;
            if (bus.AVR_ADDR_LOAD || (w_req_ok && bus.AVR_WE)) begin
                r_pf_pend  <= 1'b0;
                r_pf_valid <= 1'b0;
                r_pf_ok    <= 1'b0;
            end
        end
    end
`else
    assign w_pf_pend = 1'b0;
    assign w_pf_data = '0;
    assign w_hit_q   = 1'b0;
    assign w_hit_now = 1'b0;
`endif

    assign bus.MODE          = r_mode;
    assign bus.SNES_DATA_OUT = r_snes_dout;
    assign bus.SNES_DATA_OE  = r_snes_oe;
    assign bus.SRAM_DATA_OUT = {r_wbyte, r_wbyte};
    assign bus.SRAM_DATA_OE  = w_sram_oe;
    assign bus.SRAM_OE_N     = w_oe_n;
    assign bus.SRAM_WE_N     = w_we_n;
    assign bus.SRAM_BHE_N    = w_bhe_n;
    assign bus.SRAM_BLE_N    = w_ble_n;
    assign bus.AVR_ADDR      = r_avr_addr;
    assign bus.AVR_RDATA     = r_avr_rdata;
    assign bus.AVR_ACK       = w_avr_done | w_hit_q;
    assign bus.AVR_BUSY      = w_busy;

endmodule

// File: tb/tb_mem_sequencer.sv
// tb_mem_sequencer: randomized SNES/AVR traffic against a transaction-level
// model; the bench also plays the address decoder and a read-only SRAM.
module tb_mem_sequencer;
    import mem_seq_pkg::*;

    localparam int ACC = 4;
`ifdef MEM_SEQ_AVR_PREFETCH_EN
    localparam bit PF = 1'b1;
`else
    localparam bit PF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_seq_if bus();

    mem_sequencer #(
        .SYNC_STAGES(2), .ACCESS_CYCLES(ACC), .AVR_INC(1)
    ) dut (
        .CLK(clk), .RST(rst), .bus(bus.slave)
    );

    logic rd_n = 1'b1, wr_n = 1'b1;
    logic is_rom = 1'b0, is_sav = 1'b0, s_a0 = 1'b0;
    logic [15:0] s_sram = '0;
    logic [7:0]  s_din = '0, a_wd = '0;
    logic [23:0] a_ldv = '0;
    logic a_ld = 1'b0, a_req = 1'b0, a_we = 1'b0;

    function automatic logic [15:0] memval(input logic [23:0] a);
        return {a[7:0] ^ a[23:16] ^ 8'h3C, a[15:8] + a[7:0] + 8'h11};
    endfunction

    function automatic logic [7:0] ref_byte(input logic [23:0] a);
        logic [15:0] w;
        w = memval(a);
        return a[0] ? w[15:8] : w[7:0];
    endfunction

    assign bus.SNES_RD_N     = rd_n;
    assign bus.SNES_WR_N     = wr_n;
    assign bus.IS_ROM        = is_rom;
    assign bus.IS_SAVERAM    = is_sav;
    assign bus.SNES_DATA_IN  = s_din;
    assign bus.AVR_ADDR_IN   = a_ldv;
    assign bus.AVR_ADDR_LOAD = a_ld;
    assign bus.AVR_REQ       = a_req;
    assign bus.AVR_WE        = a_we;
    assign bus.AVR_WDATA     = a_wd;
    assign bus.SRAM_ADDR0    = bus.MODE ? bus.AVR_ADDR[0] : s_a0;
    assign bus.SRAM_DATA_IN  = bus.MODE ? memval(bus.AVR_ADDR) : s_sram;

    int errors = 0, checks = 0;
    int cyc_oe = 0, cyc_we = 0, n_ack = 0, n_lo = 0, n_hi = 0;

    logic [23:0] m_ptr = '0;
    bit          m_pfv = 1'b0;
    logic [7:0]  m_sout = '0;

    always @(negedge clk) begin
        if (!bus.SRAM_OE_N) cyc_oe <= cyc_oe + 1;
        if (!bus.SRAM_WE_N) cyc_we <= cyc_we + 1;
        if (bus.AVR_ACK) n_ack <= n_ack + 1;
        if (!bus.SRAM_OE_N || !bus.SRAM_WE_N) begin
            if (!bus.SRAM_BLE_N) n_lo <= n_lo + 1;
            if (!bus.SRAM_BHE_N) n_hi <= n_hi + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic snes_rd(input bit rom, input bit sav, input bit a0,
                           input logic [15:0] d);
        int oe0, lo0, hi0, n;
        bit mapped;
        mapped = rom | sav;
        n = mapped ? ACC : 0;
        @(negedge clk);
        is_rom = rom; is_sav = sav; s_a0 = a0; s_sram = d;
        oe0 = cyc_oe; lo0 = n_lo; hi0 = n_hi;
        rd_n = 1'b0;
        repeat (14) @(negedge clk);
        check("rd_oe_cyc", cyc_oe - oe0, n);
        check("rd_lane", a0 ? n_hi - hi0 : n_lo - lo0, n);
        check("rd_other_lane", a0 ? n_lo - lo0 : n_hi - hi0, 0);
        if (mapped) m_sout = a0 ? d[15:8] : d[7:0];
        check("rd_data", bus.SNES_DATA_OUT, m_sout);
        check("rd_doe_on", bus.SNES_DATA_OE, mapped);
        check("rd_mode", bus.MODE, 0);
        rd_n = 1'b1;
        repeat (5) @(negedge clk);
        check("rd_doe_off", bus.SNES_DATA_OE, 0);
    endtask

    task automatic snes_wr(input bit rom, input bit sav,
                           input logic [7:0] d);
        int we0, oe0;
        @(negedge clk);
        is_rom = rom; is_sav = sav; s_a0 = d[0]; s_din = d;
        we0 = cyc_we; oe0 = cyc_oe;
        wr_n = 1'b0;
        repeat (14) @(negedge clk);
        check("wr_we_cyc", cyc_we - we0, sav ? ACC : 0);
        check("wr_oe_cyc", cyc_oe - oe0, 0);
        if (sav) check("wr_data", bus.SRAM_DATA_OUT, {d, d});
        wr_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic avr_load(input logic [23:0] v);
        @(negedge clk);
        a_ld = 1'b1; a_ldv = v;
        @(negedge clk);
        a_ld = 1'b0;
        m_ptr = v; m_pfv = 1'b0;
        @(negedge clk);
        check("ld_ptr", bus.AVR_ADDR, v);
    endtask

    task automatic avr_op(input bit we, input logic [7:0] wd);
        logic [23:0] p;
        int lat, exp_lat, we0, ack0;
        bit got;
        p = m_ptr;
        exp_lat = (PF && m_pfv && !we) ? 1 : ACC + 3;
        @(negedge clk);
        we0 = cyc_we; ack0 = n_ack;
        a_req = 1'b1; a_we = we; a_wd = wd;
        lat = 0; got = 1'b0;
        while (!got && lat < 40) begin
            @(negedge clk);
            a_req = 1'b0;
            lat++;
            got = bus.AVR_ACK;
        end
        check("avr_lat", lat, exp_lat);
        if (!we) check("avr_rdata", bus.AVR_RDATA, ref_byte(p));
        if (exp_lat != 1) check("avr_mode", bus.MODE, 1);
        repeat (12) @(negedge clk);
        if (we) begin
            check("avr_we_cyc", cyc_we - we0, ACC);
            check("avr_wdata", bus.SRAM_DATA_OUT, {wd, wd});
        end
        m_ptr = p + 24'd1;
        m_pfv = !we;
        check("avr_ptr", bus.AVR_ADDR, m_ptr);
        check("avr_busy", bus.AVR_BUSY, 0);
        check("avr_ack_once", n_ack - ack0, 1);
    endtask

    initial begin
        int oe0, ack0, lat;
        bit got;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mode", bus.MODE, 0);
        check("rst_strobes", {bus.SRAM_OE_N, bus.SRAM_WE_N,
              bus.SRAM_BHE_N, bus.SRAM_BLE_N}, 4'hF);
        check("rst_oes", {bus.SNES_DATA_OE, bus.SRAM_DATA_OE}, 0);
        check("rst_sout", bus.SNES_DATA_OUT, 0);
        check("rst_rdata", bus.AVR_RDATA, 0);
        check("rst_ptr", bus.AVR_ADDR, 0);
        check("rst_ack", bus.AVR_ACK, 0);
        check("rst_busy", bus.AVR_BUSY, 0);

        // SNES fall and AVR read request land on the same cycle
        is_rom = 1'b1; is_sav = 1'b0; s_a0 = 1'b0; s_sram = 16'h1234;
        oe0 = cyc_oe; ack0 = n_ack;
        rd_n = 1'b0;
        repeat (2) @(negedge clk);
        a_req = 1'b1; a_we = 1'b0;
        lat = 0; got = 1'b0;
        while (!got && lat < 40) begin
            @(negedge clk);
            a_req = 1'b0;
            lat++;
            got = bus.AVR_ACK;
        end
        check("sim_lat", lat, 13);
        check("sim_oe_cyc", cyc_oe - oe0, 2 * ACC);
        check("sim_rdata", bus.AVR_RDATA, ref_byte(24'h0));
        check("sim_sout", bus.SNES_DATA_OUT, 8'h34);
        repeat (12) @(negedge clk);
        check("sim_ack_once", n_ack - ack0, 1);
        m_ptr = 24'd1; m_pfv = 1'b1; m_sout = 8'h34;
        rd_n = 1'b1;
        repeat (5) @(negedge clk);

        snes_rd(1'b1, 1'b0, 1'b1, 16'hA55A);
        snes_rd(1'b0, 1'b0, 1'b0, 16'h7788);
        snes_wr(1'b1, 1'b0, 8'h3C);
        snes_wr(1'b0, 1'b1, 8'h3C);

        avr_load(24'hFFFFFF);
        avr_op(1'b0, 8'h00);
        avr_load(24'h000100);
        avr_op(1'b0, 8'h00);
        avr_op(1'b0, 8'h00);
        avr_op(1'b1, 8'hC3);

        // Reset in the middle of an AVR write strobe
        avr_load(24'h123456);
        ack0 = n_ack;
        @(negedge clk);
        a_req = 1'b1; a_we = 1'b1; a_wd = 8'h5A;
        @(negedge clk);
        a_req = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pre_we", bus.SRAM_WE_N, 0);
        #1 rst = 1'b1;
        #1;
        check("rst_mid_we", bus.SRAM_WE_N, 1);
        check("rst_mid_busy", bus.AVR_BUSY, 0);
        check("rst_mid_ptr", bus.AVR_ADDR, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("rst_no_ack", n_ack - ack0, 0);
        m_ptr = '0; m_pfv = 1'b0; m_sout = '0;
        check("rst_sout2", bus.SNES_DATA_OUT, 0);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0: snes_rd(1'($urandom), 1'($urandom), 1'($urandom),
                           16'($urandom));
                1: snes_wr(1'($urandom), 1'($urandom), 8'($urandom));
                2: avr_op(1'b1, 8'($urandom));
                3: begin
                    case ($urandom_range(0, 2))
                        0: avr_load(24'hFFFFFE);
                        1: avr_load(24'hFFFFFF);
                        default: avr_load(24'($urandom));
                    endcase
                end
                default: avr_op(1'b0, 8'h00);
            endcase
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
